// File: rtl/pace_ctrl_param.sv
// pace_ctrl_param: single-chamber pacing controller with demand (sense-inhibited)
// and fixed-rate modes. Phases cycle ALERT -> PACE -> REFRACT -> ALERT, and a
// sensed intrinsic beat in ALERT skips the pace.
// Optional build macro PACE_HYST_EN: after a sensed-beat refractory, the next
// ALERT uses the longer HYS_CYC escape interval.
module pace_ctrl_param #(
  parameter int CNT_W   = 24,
  parameter int ESC_CYC = 12000000,
  parameter int PW_CYC  = 12000,
  parameter int REF_CYC = 3600000,
  parameter int HYS_CYC = 14400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sense_in,
  input  logic [1:0] mode,
  output logic       pace,
  output logic       sensed,
  output logic [1:0] state,
  output logic [7:0] pace_cnt
);

  // Every interval must be reachable by the phase counter without wrapping.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);
  localparam longint L_ESC   = longint'(ESC_CYC);
  localparam longint L_PW    = longint'(PW_CYC);
  localparam longint L_REF   = longint'(REF_CYC);
  localparam longint L_HYS   = longint'(HYS_CYC);
  localparam bit CFG_OK = (L_ESC >= 1) && (L_ESC <= CNT_MAX) &&
                          (L_PW  >= 1) && (L_PW  <= CNT_MAX) &&
                          (L_REF >= 1) && (L_REF <= CNT_MAX) &&
                          (L_HYS >= 1) && (L_HYS <= CNT_MAX);

  if (!CFG_OK) begin : g_cfg_check
    $error("pace_ctrl_param: a *_CYC parameter is outside 1..2^CNT_W-1");
  end

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] ESC_TC = CNT_W'(ESC_CYC - 1);
  localparam logic [CNT_W-1:0] PW_TC  = CNT_W'(PW_CYC - 1);
  localparam logic [CNT_W-1:0] REF_TC = CNT_W'(REF_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ALERT   = 2'b01,
    ST_PACE    = 2'b10,
    ST_REFRACT = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sync1, r_sync2, r_sync3, r_edge;
  logic [7:0]       r_pace_cnt;
  logic             w_demand, w_off, w_sensed, w_esc_tc, w_pace_entry;

  assign w_off    = (mode == 2'b00);
  assign w_demand = (mode == 2'b01) || (mode == 2'b11);
  // A beat is accepted only while waiting for it in demand mode.
  assign w_sensed = (r_state == ST_ALERT) && w_demand && r_edge;

`ifdef PACE_HYST_EN
  localparam logic [CNT_W-1:0] HYS_TC = CNT_W'(HYS_CYC - 1);
  logic r_hyst;

  assign w_esc_tc = r_hyst ? (r_cnt == HYS_TC) : (r_cnt == ESC_TC);

  // Remember whether the last cycle-ending event was a sensed beat or a pace.
  always_ff @(posedge clk) begin
    if (!rst_n || w_off || (r_state == ST_IDLE)) begin
      r_hyst <= 1'b0;
    end else if (w_sensed) begin
      r_hyst <= 1'b1;
    end else if (w_pace_entry) begin
      r_hyst <= 1'b0;
    end
  end
`else
  assign w_esc_tc = (r_cnt == ESC_TC);
`endif

  // Two-flop synchroniser on the asynchronous detector, then a registered
  // rising-edge detector (event lands 3 cycles after the input rises).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= sense_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // Phase register and phase counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-phase logic; a sensed beat beats the escape terminal count, and
  // mode off overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_pace_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_ALERT;
      end
      ST_ALERT: begin
        if (w_sensed) begin
          w_state_nxt = ST_REFRACT;
          w_cnt_nxt   = '0;
        end else if (w_esc_tc) begin
          w_state_nxt  = ST_PACE;
          w_cnt_nxt    = '0;
          w_pace_entry = 1'b1;
        end
      end
      ST_PACE: begin
        if (r_cnt == PW_TC) begin
          w_state_nxt = ST_REFRACT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (r_cnt == REF_TC) begin
          w_state_nxt = ST_ALERT;
          w_cnt_nxt   = '0;
        end
      end
    endcase
    if (w_off) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = '0;
      w_pace_entry = 1'b0;
    end
  end

  // Delivered-pace counter, saturating at 255; holds across mode-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pace_cnt <= 8'd0;
    end else if (w_pace_entry && (r_pace_cnt != 8'hFF)) begin
      r_pace_cnt <= r_pace_cnt + 8'd1;
    end
  end

  // Pace drops in the same cycle mode goes off, truncating the pulse.
  assign pace     = (r_state == ST_PACE) && !w_off;
  assign sensed   = w_sensed;
  assign state    = r_state;
  assign pace_cnt = r_pace_cnt;

endmodule

// File: tb/tb_pace_ctrl_param.sv
// Testbench for pace_ctrl_param with ESC=10, PW=2, REF=4, HYS=15, CNT_W=8.
// Reference model tracks the phase and the cycles remaining in it.
module tb_pace_ctrl_param;

  localparam int ESC  = 10;
  localparam int PW   = 2;
  localparam int REFC = 4;
  localparam int HYS  = 15;
`ifdef PACE_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif
  localparam int PH_IDLE = 0, PH_ALERT = 1, PH_PACE = 2, PH_REFRACT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sense_in = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       pace, sensed;
  logic [1:0] state;
  logic [7:0] pace_cnt;

  int errors = 0;
  int checks = 0;

  // Model state
  int         m_phase = PH_IDLE;
  int         m_left  = 0;
  int         m_paces = 0;
  bit         m_last  = 1'b0;
  bit         smp[$];
  logic [1:0] e_state;
  logic       e_pace, e_sensed;
  logic [7:0] e_cnt;

  pace_ctrl_param #(
    .CNT_W(8), .ESC_CYC(ESC), .PW_CYC(PW), .REF_CYC(REFC), .HYS_CYC(HYS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sense_in(sense_in), .mode(mode),
    .pace(pace), .sensed(sensed), .state(state), .pace_cnt(pace_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle from model state and current inputs.
  task automatic model_eval();
    logic dem, evt;
    dem      = (mode == 2'b01) || (mode == 2'b11);
    evt      = smp[2] && !smp[3];
    e_state  = 2'(m_phase);
    e_pace   = (m_phase == PH_PACE) && (mode != 2'b00);
    e_sensed = (m_phase == PH_ALERT) && dem && evt;
    e_cnt    = (m_paces > 255) ? 8'd255 : 8'(m_paces);
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_tick();
    logic dem, acc;
    dem = (mode == 2'b01) || (mode == 2'b11);
    acc = (m_phase == PH_ALERT) && dem && smp[2] && !smp[3];
    if (!rst_n) begin
      m_phase = PH_IDLE;
      m_paces = 0;
      m_last  = 1'b0;
      smp     = '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      smp.push_front(sense_in);
      void'(smp.pop_back());
      if (mode == 2'b00) begin
        m_phase = PH_IDLE;
        m_last  = 1'b0;
      end else begin
        case (m_phase)
          PH_IDLE: begin
            m_phase = PH_ALERT;
            m_left  = ESC;
            m_last  = 1'b0;
          end
          PH_ALERT: begin
            if (acc) begin
              m_phase = PH_REFRACT;
              m_left  = REFC;
              m_last  = HYST;
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_phase = PH_PACE;
                m_left  = PW;
                m_paces++;
                m_last  = 1'b0;
              end
            end
          end
          PH_PACE: begin
            m_left--;
            if (m_left == 0) begin
              m_phase = PH_REFRACT;
              m_left  = REFC;
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) begin
              m_phase = PH_ALERT;
              m_left  = m_last ? HYS : ESC;
            end
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  // Reset for two edges, then release with the given mode; returns at cycle 0.
  task automatic start_run(input logic [1:0] md);
    rst_n = 1'b0;
    sense_in = 1'b0;
    mode = md;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 2'b10;
    tick();
    for (int k = 0; k < 4; k++) begin
      sense_in = k[0];
      @(negedge clk);
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {2'b00, 1'b0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset k=%0d got state=%0d pace=%0b sensed=%0b cnt=%0d want 0 0 0 0",
                 k, state, pace, sensed, pace_cnt);
      end
      tick();
    end
  endtask

  task automatic test_fixed_rate();
    start_run(2'b10);
    for (int k = 0; k < 48; k++) begin
      sense_in = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL fixed_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      checks++;
      if (pace !== ((k % 16 == 10) || (k % 16 == 11))) begin
        errors++;
        $display("FAIL fixed_pace k=%0d got pace=%0b", k, pace);
      end
      if (k == 44) begin
        checks++;
        if (pace_cnt !== 8'd3) begin
          errors++;
          $display("FAIL fixed_count got %0d want 3", pace_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_demand_inhibit();
    start_run(2'b01);
    for (int k = 0; k < 80; k++) begin
      sense_in = ((k % 8) < 2);
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL demand_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      checks++;
      if ({pace, sensed, pace_cnt} !== {1'b0, (k % 8 == 3), 8'd0}) begin
        errors++;
        $display("FAIL demand_inhibit k=%0d got pace=%0b sensed=%0b cnt=%0d want 0 %0b 0",
                 k, pace, sensed, pace_cnt, (k % 8 == 3));
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    start_run(2'b01);
    for (int k = 0; k < 16; k++) begin
      sense_in = (k >= 6) && (k <= 8);
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL simul_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      checks++;
      if ({pace, sensed} !== {1'b0, (k == 9)}) begin
        errors++;
        $display("FAIL simul_outputs k=%0d got pace=%0b sensed=%0b want 0 %0b",
                 k, pace, sensed, (k == 9));
      end
      if (k == 10) begin
        checks++;
        if (state !== 2'b11) begin
          errors++;
          $display("FAIL simul_state got %0d want 3", state);
        end
      end
      tick();
    end
  endtask

  task automatic test_refractory_blank();
    int fp;
    fp = HYST ? 23 : 18;
    start_run(2'b01);
    for (int k = 0; k < 26; k++) begin
      sense_in = (k == 0) || (k == 3);
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL blank_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      checks++;
      if ({pace, sensed} !== {((k == fp) || (k == fp + 1)), (k == 3)}) begin
        errors++;
        $display("FAIL blank_outputs k=%0d got pace=%0b sensed=%0b want %0b %0b",
                 k, pace, sensed, ((k == fp) || (k == fp + 1)), (k == 3));
      end
      tick();
    end
  endtask

  task automatic test_abort();
    start_run(2'b10);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) mode = 2'b00;
      if (k == 14) mode = 2'b10;
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL abort_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      if (k == 11 || k == 13) begin
        checks++;
        if ({state, pace, pace_cnt} !== {2'b00, 1'b0, 8'd1}) begin
          errors++;
          $display("FAIL abort_modeoff k=%0d got state=%0d pace=%0b cnt=%0d want 0 0 1",
                   k, state, pace, pace_cnt);
        end
      end
      tick();
    end
    start_run(2'b10);
    for (int k = 0; k < 14; k++) begin
      if (k == 10) rst_n = 1'b0;
      if (k == 11) rst_n = 1'b1;
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL abort_rst_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      if (k == 11) begin
        checks++;
        if ({state, pace, pace_cnt} !== {2'b00, 1'b0, 8'd0}) begin
          errors++;
          $display("FAIL abort_reset got state=%0d pace=%0b cnt=%0d want 0 0 0",
                   state, pace, pace_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_mode_switch();
    start_run(2'b10);
    for (int k = 0; k < 13; k++) begin
      if (k == 5) mode = 2'b01;
      @(negedge clk);
      checks++;
      if (pace !== ((k == 10) || (k == 11))) begin
        errors++;
        $display("FAIL switch_pace k=%0d got pace=%0b", k, pace);
      end
      tick();
    end
  endtask

  task automatic test_hysteresis_sat();
    int  first_p, second_p;
    bit  prev;
    first_p = -1;
    second_p = -1;
    prev = 1'b0;
    start_run(2'b01);
    for (int k = 0; k < 4900; k++) begin
      sense_in = (k == 0);
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL hyst_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      if (pace && !prev) begin
        if (first_p < 0) first_p = k;
        else if (second_p < 0) second_p = k;
      end
      prev = pace;
      tick();
    end
    checks++;
    if (first_p != (HYST ? 23 : 18)) begin
      errors++;
      $display("FAIL hyst_first got %0d want %0d", first_p, HYST ? 23 : 18);
    end
    checks++;
    if (second_p != first_p + 16) begin
      errors++;
      $display("FAIL hyst_period got %0d want %0d", second_p, first_p + 16);
    end
    checks++;
    if (pace_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_count got %0d want 255", pace_cnt);
    end
  endtask

  task automatic test_random();
    start_run(2'b01);
    for (int k = 0; k < 3000; k++) begin
      int r;
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 15);
        mode = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r <= 12) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 5) == 0) sense_in = ~sense_in;
      rst_n = ($urandom_range(0, 499) != 0);
      @(negedge clk);
      model_eval();
      checks++;
      if ({state, pace, sensed, pace_cnt} !== {e_state, e_pace, e_sensed, e_cnt}) begin
        errors++;
        $display("FAIL random_model k=%0d got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", k,
                 state, pace, sensed, pace_cnt, e_state, e_pace, e_sensed, e_cnt);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    smp = '{1'b0, 1'b0, 1'b0, 1'b0};
    test_reset();
    test_fixed_rate();
    test_demand_inhibit();
    test_simultaneous();
    test_refractory_blank();
    test_abort();
    test_mode_switch();
    test_hysteresis_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
